// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with 2-bit direction counters.
// Combinational lookup for fetch, registered single-port update from execute.
module btb_assoc #(
    parameter int PC_WIDTH     = 32,
    parameter int TARGET_WIDTH = 32,
    parameter int NUM_SETS     = 16,
    parameter int NUM_WAYS     = 2,
    parameter int TAG_WIDTH    = 9,
    parameter int PC_LSB       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PC_WIDTH-1:0]     lookup_pc,
    output logic                    hit,
    output logic                    pred_taken,
    output logic [TARGET_WIDTH-1:0] pred_target,
    input  logic                    upd_valid,
    input  logic [PC_WIDTH-1:0]     upd_pc,
    input  logic                    upd_taken,
    input  logic [TARGET_WIDTH-1:0] upd_target,
    input  logic                    flush
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);

    logic                    valid_reg  [NUM_SETS][NUM_WAYS];
    logic [1:0]              ctr_reg    [NUM_SETS][NUM_WAYS];
    logic [TAG_WIDTH-1:0]    tag_reg    [NUM_SETS][NUM_WAYS];
    logic [TARGET_WIDTH-1:0] target_reg [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]        victim_reg [NUM_SETS];

    logic [IDX_W-1:0]     lk_idx, up_idx;
    logic [TAG_WIDTH-1:0] lk_tag, up_tag;
    logic [NUM_WAYS-1:0]  lk_match, up_match, up_free;
    logic [WAY_W-1:0]     lk_way, up_hit_way, free_way, alloc_way;
    logic                 up_hit;
    logic [1:0]           up_ctr;

    assign lk_idx = lookup_pc[PC_LSB +: IDX_W];
    assign lk_tag = lookup_pc[PC_LSB+IDX_W +: TAG_WIDTH];
    assign up_idx = upd_pc[PC_LSB +: IDX_W];
    assign up_tag = upd_pc[PC_LSB+IDX_W +: TAG_WIDTH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            assign lk_match[gi] = valid_reg[lk_idx][gi] && (tag_reg[lk_idx][gi] == lk_tag);
            assign up_match[gi] = valid_reg[up_idx][gi] && (tag_reg[up_idx][gi] == up_tag);
            assign up_free[gi]  = !valid_reg[up_idx][gi];
        end
    endgenerate

    // Descending scan so the lowest matching / free way wins.
    always_comb begin
        lk_way     = '0;
        up_hit_way = '0;
        free_way   = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (lk_match[i]) lk_way     = WAY_W'(i);
            if (up_match[i]) up_hit_way = WAY_W'(i);
            if (up_free[i])  free_way   = WAY_W'(i);
        end
    end

    assign up_hit    = |up_match;
    assign up_ctr    = ctr_reg[up_idx][up_hit_way];
    assign alloc_way = (|up_free) ? free_way : victim_reg[up_idx];

    assign hit         = |lk_match;
    assign pred_taken  = hit && ctr_reg[lk_idx][lk_way][1];
    assign pred_target = hit ? target_reg[lk_idx][lk_way] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                victim_reg[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_reg[s][w] <= 1'b0;
                    ctr_reg[s][w]   <= 2'd0;
                end
            end
        end else if (flush) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                victim_reg[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_reg[s][w] <= 1'b0;
                end
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (up_ctr != 2'd3) ctr_reg[up_idx][up_hit_way] <= up_ctr + 2'd1;
                end else begin
                    if (up_ctr != 2'd0) ctr_reg[up_idx][up_hit_way] <= up_ctr - 2'd1;
                end
            end else if (upd_taken) begin
                valid_reg[up_idx][alloc_way] <= 1'b1;
                ctr_reg[up_idx][alloc_way]   <= 2'd2;
                victim_reg[up_idx]           <= WAY_W'(alloc_way + 1'b1);
            end
        end
    end

    // Tags and targets carry no reset; the valid bits alone gate them.
    always_ff @(posedge clk) begin
        if (upd_valid && !flush) begin
            if (up_hit) begin
                target_reg[up_idx][up_hit_way] <= upd_target;
            end else if (upd_taken) begin
                tag_reg[up_idx][alloc_way]    <= up_tag;
                target_reg[up_idx][alloc_way] <= upd_target;
            end
        end
    end
endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc: default geometry, index = pc[5:2], tag = pc[14:6].
module tb_btb_assoc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        flush = 1'b0;

    int checks = 0;
    int errors = 0;

    btb_assoc dut (
        .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc),
        .hit(hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .flush(flush)
    );

    always #5 clk = ~clk;

    // Present an update for exactly one clock edge.
    task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_valid = 1'b1;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        $display("upd pc=%h taken=%0b target=%h", pc, tk, tgt);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        $display("flush");
    endtask

    task automatic look(input logic [31:0] pc);
        lookup_pc = pc; #1;
        $display("lookup pc=%h hit=%0b taken=%0b target=%h", pc, hit, pred_taken, pred_target);
    endtask

    task automatic test_reset();
        look(32'h40);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", hit); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b want 0", pred_taken); end
        checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL reset_target: got %h want 0", pred_target); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_alloc();
        do_update(32'h40, 1'b1, 32'h100);
        look(32'h40);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL alloc_hit: got %b want 1", hit); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_taken: got %b want 1", pred_taken); end
        checks++; if (pred_target !== 32'h100) begin errors++; $display("FAIL alloc_target: got %h want 100", pred_target); end
        look(32'h44);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL other_set_hit: got %b want 0", hit); end
        checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL other_set_target: got %h want 0", pred_target); end
    endtask

    task automatic test_counter();
        do_flush();
        do_update(32'h40, 1'b1, 32'h100);   // ctr=2
        do_update(32'h40, 1'b0, 32'h100);   // ctr=1
        look(32'h40);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr1_taken: got %b want 0", pred_taken); end
        do_update(32'h40, 1'b0, 32'h100);   // ctr=0
        look(32'h40);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL ctr0_hit: got %b want 1", hit); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr0_taken: got %b want 0", pred_taken); end
        do_update(32'h40, 1'b0, 32'h100);   // saturates at 0
        do_update(32'h40, 1'b1, 32'h100);   // 1
        look(32'h40);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_floor_taken: got %b want 0", pred_taken); end
        for (int i = 0; i < 4; i++) do_update(32'h40, 1'b1, 32'h100);  // 2,3,3,3
        look(32'h40);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL ctr3_taken: got %b want 1", pred_taken); end
        do_update(32'h40, 1'b0, 32'h100);   // 2
        look(32'h40);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL ctr2_taken: got %b want 1", pred_taken); end
        do_update(32'h40, 1'b1, 32'h200);   // 3, new target
        look(32'h40);
        checks++; if (pred_target !== 32'h200) begin errors++; $display("FAIL retarget: got %h want 200", pred_target); end
        do_update(32'h40, 1'b0, 32'h200);   // 2
        do_update(32'h40, 1'b0, 32'h200);   // 1
        look(32'h40);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_down_taken: got %b want 0", pred_taken); end
    endtask

    task automatic test_replacement();
        do_flush();
        do_update(32'h40, 1'b1, 32'hA40);   // way0
        do_update(32'h80, 1'b1, 32'hA80);   // way1
        do_update(32'hC0, 1'b1, 32'hAC0);   // evicts way0 (0x40)
        look(32'h40);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL evict40_hit: got %b want 0", hit); end
        look(32'h80);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL keep80_hit: got %b want 1", hit); end
        look(32'hC0);
        checks++; if (pred_target !== 32'hAC0) begin errors++; $display("FAIL c0_target: got %h want ac0", pred_target); end
        do_update(32'h100, 1'b1, 32'hB00);  // evicts way1 (0x80)
        look(32'h80);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL evict80_hit: got %b want 0", hit); end
        do_update(32'h140, 1'b0, 32'hB40);  // not-taken miss: no allocation
        look(32'h140);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL nt_alloc_hit: got %b want 0", hit); end
        look(32'hC0);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL keepc0_hit: got %b want 1", hit); end
        look(32'h100);
        checks++; if (pred_target !== 32'hB00) begin errors++; $display("FAIL keep100_target: got %h want b00", pred_target); end
    endtask

    task automatic test_back_to_back();
        // Update and lookup of the same PC in one cycle: old contents seen.
        lookup_pc = 32'h140;
        upd_pc = 32'h140; upd_taken = 1'b1; upd_target = 32'hC40; upd_valid = 1'b1;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL no_bypass_hit: got %b want 0", hit); end
        @(posedge clk); #1;
        upd_valid = 1'b0;
        $display("upd pc=00000140 taken=1 target=00000c40 (same-cycle lookup)");
        look(32'h140);
        checks++; if (pred_target !== 32'hC40) begin errors++; $display("FAIL b2b_target: got %h want c40", pred_target); end
        look(32'hC0);   // 0x140 displaced way0 (0xC0)
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL b2b_evictc0_hit: got %b want 0", hit); end
    endtask

    task automatic test_flush();
        lookup_pc = 32'h100;
        flush = 1'b1;
        upd_pc = 32'h80; upd_taken = 1'b1; upd_target = 32'hD80; upd_valid = 1'b1;
        #1;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL flush_cycle_hit: got %b want 1", hit); end
        @(posedge clk); #1;
        flush = 1'b0; upd_valid = 1'b0;
        $display("flush with update pc=00000080");
        look(32'h40);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush40_hit: got %b want 0", hit); end
        look(32'h80);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush80_hit: got %b want 0", hit); end
        look(32'hC0);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flushc0_hit: got %b want 0", hit); end
        look(32'h100);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush100_hit: got %b want 0", hit); end
        do_update(32'h40, 1'b1, 32'hE40);   // way0
        do_update(32'h80, 1'b1, 32'hE80);   // way1
        do_update(32'hC0, 1'b1, 32'hEC0);   // evicts way0
        look(32'h40);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL refill40_hit: got %b want 0", hit); end
        look(32'h80);
        checks++; if (pred_target !== 32'hE80) begin errors++; $display("FAIL refill80_target: got %h want e80", pred_target); end
    endtask

    task automatic test_reset_mid();
        look(32'h80);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL pre_reset_hit: got %b want 1", hit); end
        #2 rst_n = 1'b0;
        #1;
        $display("async reset asserted");
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL async_reset_hit: got %b want 0", hit); end
        checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL async_reset_target: got %h want 0", pred_target); end
        upd_pc = 32'h44; upd_taken = 1'b1; upd_target = 32'hF44; upd_valid = 1'b1;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        $display("upd pc=00000044 taken=1 target=00000f44 (first cycle after reset)");
        look(32'h44);
        checks++; if (pred_target !== 32'hF44) begin errors++; $display("FAIL post_reset_target: got %h want f44", pred_target); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL post_reset_taken: got %b want 1", pred_taken); end
        look(32'hC0);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL post_reset_c0_hit: got %b want 0", hit); end
    endtask

    initial begin
        #2;
        test_reset();
        test_alloc();
        test_counter();
        test_replacement();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
